msk_aes128_round_sequencer: RTL and testbench

// Control and state-register stage wrapped around the masked AES-128 round unit (SB/SR/MC + KS).

---
 rtl/msk_aes128_round_sequencer_if.sv | 23 ++
 rtl/msk_aes128_round_sequencer.sv | 115 +++++++++++
 tb/tb_msk_aes128_round_sequencer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msk_aes128_round_sequencer_if.sv
// Input (plaintext/key) and output (ciphertext) handshake bundle of the masked AES-128 round sequencer.
// Shares are concatenated: share i occupies bits [128*i +: 128].
interface msk_aes128_round_sequencer_if #(
  parameter int unsigned d = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [128*d-1:0] sh_plaintext;
  logic [128*d-1:0] sh_key;
  logic             out_valid;
  logic             out_ready;
  logic [128*d-1:0] sh_ciphertext;

  modport master (
    output in_valid, sh_plaintext, sh_key, out_ready,
    input  in_ready, out_valid, sh_ciphertext
  );

  modport slave (
    input  in_valid, sh_plaintext, sh_key, out_ready,
    output in_ready, out_valid, sh_ciphertext
  );
endinterface

// File: rtl/msk_aes128_round_sequencer.sv
// Control and state-register stage around a masked AES-128 round unit: initial AddRoundKey,
// ten round iterations with share-wise AddRoundKey, ciphertext handshake, then pipeline cleaning.
module msk_aes128_round_sequencer #(
  parameter int unsigned d       = 2,
  parameter int unsigned LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  msk_aes128_round_sequencer_if.slave bus,
  output logic [128*d-1:0]     sh_state_to_rnd,
  output logic [128*d-1:0]     sh_key_to_rnd,
  output logic [8*d-1:0]       sh_RCON_to_rnd,
  output logic                 cleaning_on,
  output logic                 round_active,
  input  logic [128*d-1:0]     sh_state_from_rnd,
  input  logic [128*d-1:0]     sh_SR_from_rnd,
  input  logic [128*d-1:0]     sh_key_from_rnd
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] CLEAN = 2'd3;

  localparam int unsigned    LW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LW-1:0]  LAT_LAST = LW'(LATENCY - 1);

  logic [1:0]       fsm;
  logic [128*d-1:0] state_reg;
  logic [128*d-1:0] key_reg;
  logic [3:0]       rnd_cnt;
  logic [LW-1:0]    lat_cnt;
  logic [7:0]       rcon;
  logic             lat_last;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  assign lat_last = (lat_cnt == LAT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      state_reg <= '0;
      key_reg   <= '0;
      rnd_cnt   <= '0;
      lat_cnt   <= '0;
      rcon      <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg <= bus.sh_plaintext ^ bus.sh_key;
            key_reg   <= bus.sh_key;
            rnd_cnt   <= 4'd1;
            lat_cnt   <= '0;
            rcon      <= 8'h01;
            fsm       <= ROUND;
          end
        end
        ROUND: begin
          // Round unit inputs stay frozen until its outputs are captured on the last latency cycle.
          if (lat_last) begin
            key_reg <= sh_key_from_rnd;
            lat_cnt <= '0;
            if (rnd_cnt == 4'd10) begin
              state_reg <= sh_SR_from_rnd ^ sh_key_from_rnd;
              fsm       <= DONE;
            end else begin
              state_reg <= sh_state_from_rnd ^ sh_key_from_rnd;
              rcon      <= xtime(rcon);
              rnd_cnt   <= rnd_cnt + 4'd1;
            end
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg <= '0;
            key_reg   <= '0;
            lat_cnt   <= '0;
            fsm       <= CLEAN;
          end
        end
        CLEAN: begin
          if (lat_last) begin
            lat_cnt <= '0;
            fsm     <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = rst_n && (fsm == IDLE);
  assign bus.out_valid     = (fsm == DONE);
  assign bus.sh_ciphertext = (fsm == DONE) ? state_reg : '0;

  // Zero inputs outside ROUND so the ciphertext never reaches the round unit and CLEAN flushes it.
  assign sh_state_to_rnd = (fsm == ROUND) ? state_reg : '0;
  assign sh_key_to_rnd   = (fsm == ROUND) ? key_reg : '0;
  assign cleaning_on     = (fsm == CLEAN);
  assign round_active    = (fsm == ROUND) || (fsm == CLEAN);

  always_comb begin
    sh_RCON_to_rnd      = '0;
    sh_RCON_to_rnd[7:0] = rcon;
  end

endmodule

// File: tb/tb_msk_aes128_round_sequencer.sv
// Directed bench: two sequencer builds (d=2/LATENCY=4 and d=3/LATENCY=6) each wrapped by a
// behavioural round unit that recombines shares, runs one AES round and re-masks its outputs.
module tb_msk_aes128_round_sequencer;

  localparam int unsigned LA = 4;
  localparam int unsigned LB = 6;

  typedef struct packed {
    logic [127:0] st;
    logic [127:0] sr;
    logic [127:0] key;
  } rnd_t;

  logic clk;
  logic rst_n;
  int unsigned checks;
  int unsigned errors;
  logic [7:0] rcon_seq[$];

  // ---------------- reference AES round helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] e;
    logic [7:0] inv;
    logic [7:0] b;
    logic [7:0] s;
    e = 8'd254;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gmul(inv, inv);
      if (e[i]) inv = gmul(inv, a);
    end
    b = inv;
    s = inv;
    for (int i = 0; i < 4; i++) begin
      b = {b[6:0], b[7]};
      s ^= b;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xt(a0)^xt(a1)^a1^a2^a3, a0^xt(a1)^xt(a2)^a2^a3,
                           a0^a1^xt(a2)^xt(a3)^a3, xt(a0)^a0^a1^a2^xt(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 ^= t;
    w1 ^= w0;
    w2 ^= w1;
    w3 ^= w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic rnd_t rnd_fn(input logic [127:0] s, input logic [127:0] k, input logic [7:0] rc);
    rnd_t r;
    r.sr  = sub_shift(s);
    r.st  = mix(r.sr);
    r.key = key_next(k, rc);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- build A: d=2, LATENCY=4 ----------------
  logic [255:0] sta, kta, sfa, srfa, kfa;
  logic [15:0]  rca;
  logic         cla, raa;
  rnd_t         pa [LA-1];
  logic [127:0] ma_st, ma_sr, ma_k;

  msk_aes128_round_sequencer_if #(.d(2)) bus_a ();

  msk_aes128_round_sequencer #(.d(2), .LATENCY(LA)) dut_a (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus_a),
    .sh_state_to_rnd   (sta),
    .sh_key_to_rnd     (kta),
    .sh_RCON_to_rnd    (rca),
    .cleaning_on       (cla),
    .round_active      (raa),
    .sh_state_from_rnd (sfa),
    .sh_SR_from_rnd    (srfa),
    .sh_key_from_rnd   (kfa)
  );

  always @(posedge clk) begin
    pa[0] <= rnd_fn(sta[127:0] ^ sta[255:128], kta[127:0] ^ kta[255:128], rca[7:0] ^ rca[15:8]);
    for (int i = 1; i < int'(LA) - 1; i++) pa[i] <= pa[i-1];
    ma_st <= rand128();
    ma_sr <= rand128();
    ma_k  <= rand128();
  end

  assign sfa  = {ma_st, pa[LA-2].st ^ ma_st};
  assign srfa = {ma_sr, pa[LA-2].sr ^ ma_sr};
  assign kfa  = {ma_k, pa[LA-2].key ^ ma_k};

  // ---------------- build B: d=3, LATENCY=6 ----------------
  logic [383:0] stb, ktb, sfb, srfb, kfb;
  logic [23:0]  rcb;
  logic         clb, rab;
  rnd_t         pb [LB-1];
  logic [255:0] mb_st, mb_sr, mb_k;

  msk_aes128_round_sequencer_if #(.d(3)) bus_b ();

  msk_aes128_round_sequencer #(.d(3), .LATENCY(LB)) dut_b (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus_b),
    .sh_state_to_rnd   (stb),
    .sh_key_to_rnd     (ktb),
    .sh_RCON_to_rnd    (rcb),
    .cleaning_on       (clb),
    .round_active      (rab),
    .sh_state_from_rnd (sfb),
    .sh_SR_from_rnd    (srfb),
    .sh_key_from_rnd   (kfb)
  );

  always @(posedge clk) begin
    pb[0] <= rnd_fn(stb[127:0] ^ stb[255:128] ^ stb[383:256],
                    ktb[127:0] ^ ktb[255:128] ^ ktb[383:256],
                    rcb[7:0] ^ rcb[15:8] ^ rcb[23:16]);
    for (int i = 1; i < int'(LB) - 1; i++) pb[i] <= pb[i-1];
    mb_st <= {rand128(), rand128()};
    mb_sr <= {rand128(), rand128()};
    mb_k  <= {rand128(), rand128()};
  end

  assign sfb  = {mb_st, pb[LB-2].st ^ mb_st[127:0] ^ mb_st[255:128]};
  assign srfb = {mb_sr, pb[LB-2].sr ^ mb_sr[127:0] ^ mb_sr[255:128]};
  assign kfb  = {mb_k, pb[LB-2].key ^ mb_k[127:0] ^ mb_k[255:128]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  // One encryption on build A: accept, latency, ciphertext, optional back-pressure, cleaning.
  task automatic run_a(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp_ct,
                       input int unsigned hold, input bit keep_valid, output logic [255:0] ct_sh);
    logic [127:0] mp, mk, ct;
    logic [255:0] held;
    int unsigned n, cyc, bad;
    mp = rand128();
    mk = rand128();
    bus_a.sh_plaintext = {mp, pt ^ mp};
    bus_a.sh_key       = {mk, key ^ mk};
    bus_a.in_valid     = 1'b1;
    n = 0;
    while (!bus_a.in_ready && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus_a.in_ready !== 1'b1) begin
      errors++; $display("FAIL accept_wait: in_ready=%b required 1", bus_a.in_ready);
    end
    @(posedge clk); #1;
    if (!keep_valid) bus_a.in_valid = 1'b0;
    rcon_seq.delete();
    cyc = 0;
    bad = 0;
    while (!bus_a.out_valid && cyc < 200) begin
      if (bus_a.in_ready !== 1'b0 || rca[15:8] !== 8'h00 || bus_a.sh_ciphertext !== '0 || raa !== 1'b1) bad++;
      if (raa && !cla && (rcon_seq.size() == 0 || rcon_seq[$] !== rca[7:0])) rcon_seq.push_back(rca[7:0]);
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc != 10 * LA) begin
      errors++; $display("FAIL latency_a: out_valid after %0d cycles, required %0d", cyc, 10 * LA);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL busy_outputs_a: %0d bad cycles during rounds, required 0", bad);
    end
    held = bus_a.sh_ciphertext;
    ct = held[127:0] ^ held[255:128];
    checks++;
    if (ct !== exp_ct) begin
      errors++; $display("FAIL ciphertext_a: got %h required %h", ct, exp_ct);
    end
    if (hold > 0) begin
      bad = 0;
      for (int i = 0; i < int'(hold); i++) begin
        @(posedge clk); #1;
        if (bus_a.out_valid !== 1'b1 || bus_a.sh_ciphertext !== held || raa !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL done_hold: %0d unstable cycles of %0d, required 0", bad, hold);
      end
    end
    bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.out_ready = 1'b0;
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.sh_ciphertext !== '0) begin
      errors++; $display("FAIL ct_gating: out_valid=%b ct=%h required 0 and 0", bus_a.out_valid, bus_a.sh_ciphertext);
    end
    n = 0;
    bad = 0;
    while (cla && n < 50) begin
      if (raa !== 1'b1 || sta !== '0 || kta !== '0 || bus_a.in_ready !== 1'b0) bad++;
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != LA || bad != 0) begin
      errors++; $display("FAIL clean_a: %0d cleaning cycles (%0d bad) required %0d (0 bad)", n, bad, LA);
    end
    checks++;
    if (bus_a.in_ready !== 1'b1 || raa !== 1'b0) begin
      errors++; $display("FAIL ready_after_clean: in_ready=%b round_active=%b required 1 0", bus_a.in_ready, raa);
    end
    ct_sh = held;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0; bus_a.sh_plaintext = '0; bus_a.sh_key = '0;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0; bus_b.sh_plaintext = '0; bus_b.sh_key = '0;
    #2 rst_n = 1'b0;
    #20;
    checks++;
    if ({bus_a.in_ready, bus_a.out_valid, cla, raa} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: rdy/vld/clean/act=%b required 0000", {bus_a.in_ready, bus_a.out_valid, cla, raa});
    end
    checks++;
    if (sta !== '0 || kta !== '0 || rca !== '0 || bus_a.sh_ciphertext !== '0) begin
      errors++; $display("FAIL reset_data: state=%h key=%h rcon=%h required all 0", sta, kta, rca);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    checks++;
    if (bus_a.in_ready !== 1'b1 || bus_b.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: in_ready a=%b b=%b required 1 1", bus_a.in_ready, bus_b.in_ready);
    end
  endtask

  task automatic test_fips();
    logic [255:0] s;
    run_a(FIPS_PT, FIPS_KEY, FIPS_CT, 0, 1'b0, s);
  endtask

  task automatic test_resharing();
    logic [255:0] s0, s1, s2;
    run_a(FIPS_PT, FIPS_KEY, FIPS_CT, 0, 1'b0, s0);
    run_a(FIPS_PT, FIPS_KEY, FIPS_CT, 0, 1'b0, s1);
    run_a(FIPS_PT, FIPS_KEY, FIPS_CT, 0, 1'b0, s2);
    checks++;
    if (s0 === s1 || s1 === s2 || s0 === s2) begin
      errors++; $display("FAIL share_diversity: shares %h / %h / %h, required pairwise different", s0, s1, s2);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] s;
    bus_a.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_a.in_ready !== 1'b1 || cla !== 1'b0 || bus_a.out_valid !== 1'b0) begin
      errors++; $display("FAIL stray_out_ready: rdy=%b clean=%b vld=%b required 1 0 0", bus_a.in_ready, cla, bus_a.out_valid);
    end
    bus_a.out_ready = 1'b0;
    run_a(FIPS_PT, FIPS_KEY, FIPS_CT, 20, 1'b0, s);
  endtask

  task automatic test_reset_mid();
    logic [127:0] mp, mk;
    logic [255:0] s;
    mp = rand128();
    mk = rand128();
    bus_a.sh_plaintext = {mp, FIPS_PT ^ mp};
    bus_a.sh_key       = {mk, FIPS_KEY ^ mk};
    bus_a.in_valid     = 1'b1;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    checks++;
    if (rca[7:0] !== 8'h10 || raa !== 1'b1) begin
      errors++; $display("FAIL round5_rcon: rcon=%h active=%b required 10 1", rca[7:0], raa);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_a.in_ready, bus_a.out_valid, cla, raa} !== 4'b0000 || sta !== '0 || kta !== '0 ||
        rca !== '0 || bus_a.sh_ciphertext !== '0) begin
      errors++; $display("FAIL async_reset: rdy/vld/clean/act=%b rcon=%h state=%h required all 0",
                         {bus_a.in_ready, bus_a.out_valid, cla, raa}, rca, sta);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    checks++;
    if (bus_a.in_ready !== 1'b1 || raa !== 1'b0) begin
      errors++; $display("FAIL reset_abort: in_ready=%b active=%b required 1 0", bus_a.in_ready, raa);
    end
    run_a(FIPS_PT, FIPS_KEY, FIPS_CT, 0, 1'b0, s);
  endtask

  task automatic check_rcon_seq(input string tag);
    logic [7:0] exp_rc [10];
    int unsigned bad;
    exp_rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    bad = 0;
    if (rcon_seq.size() != 10) bad = 1;
    else for (int i = 0; i < 10; i++) if (rcon_seq[i] !== exp_rc[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rcon_seq_%s: %0d values, %0d wrong, first=%h last=%h required 01..36",
               tag, rcon_seq.size(), bad, rcon_seq.size() > 0 ? rcon_seq[0] : 8'h00,
               rcon_seq.size() > 0 ? rcon_seq[$] : 8'h00);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] s;
    run_a('0, '0, ZERO_CT, 0, 1'b1, s);
    check_rcon_seq("first");
    run_a('0, '0, ZERO_CT, 0, 1'b1, s);
    check_rcon_seq("second");
    bus_a.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_d3();
    logic [127:0] m0, m1, k0, k1, ct;
    int unsigned cyc, n;
    m0 = rand128(); m1 = rand128(); k0 = rand128(); k1 = rand128();
    bus_b.sh_plaintext = {m1, m0, FIPS_PT ^ m0 ^ m1};
    bus_b.sh_key       = {k1, k0, FIPS_KEY ^ k0 ^ k1};
    bus_b.in_valid     = 1'b1;
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
    cyc = 0;
    while (!bus_b.out_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (cyc != 10 * LB) begin
      errors++; $display("FAIL latency_b: out_valid after %0d cycles, required %0d", cyc, 10 * LB);
    end
    ct = bus_b.sh_ciphertext[127:0] ^ bus_b.sh_ciphertext[255:128] ^ bus_b.sh_ciphertext[383:256];
    checks++;
    if (ct !== FIPS_CT) begin
      errors++; $display("FAIL ciphertext_b: got %h required %h", ct, FIPS_CT);
    end
    bus_b.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_b.out_ready = 1'b0;
    n = 0;
    while (clb && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != LB || bus_b.in_ready !== 1'b1) begin
      errors++; $display("FAIL clean_b: %0d cleaning cycles in_ready=%b required %0d and 1", n, bus_b.in_ready, LB);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fips();
    test_resharing();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_d3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
